fp_div_arbiter: RTL and testbench
=================================

Name: fp_div_arbiter

Overview:
- Shares one fixed-point divider (Q(WIDTH-FBITS).FBITS, start/busy/valid/dbz/ovf handshake) among NREQ requesters in the LBM pipeline, e.g. per-lane density/velocity normalisation.
- Arbitrates requests round-robin and latches the granted operands.
- Issues a one-cycle start pulse to the divider and waits for the result, with a watchdog.
- Returns quotient, remainder and flags to the winner on a shared result bus with a one-hot done strobe.

Parameters:
- WIDTH, 32, operand/result width in bits.
- FBITS, 24, fractional bits. Pass-through only; the arbiter does no arithmetic.
- NREQ, 4, number of requesters (2..16).
- TIMEOUT, 64, maximum WAIT cycles before abort (≥4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- x_in  in  NREQ*WIDTH  dividends, requester i at bits [i*WIDTH +: WIDTH], signed.
- y_in  in  NREQ*WIDTH  divisors, same packing, signed.
- gnt  out  NREQ  one-hot, one-cycle accept pulse.
- done  out  NREQ  one-hot, one-cycle result strobe.
- res_id  out  $clog2(NREQ)  index of the requester owning the result bus.
- q_out  out  WIDTH  quotient.
- r_out  out  WIDTH  remainder.
- dbz_out  out  1  divide-by-zero flag.
- ovf_out  out  1  overflow flag.
- tmo_out  out  1  watchdog abort flag.
- div_start  out  1  divider start.
- div_x  out  WIDTH  divider dividend.
- div_y  out  WIDTH  divider divisor.
- div_busy  in  1  divider busy.
- div_valid  in  1  divider valid.
- div_dbz  in  1  divider divide-by-zero.
- div_ovf  in  1  divider overflow.
- div_q  in  WIDTH  divider quotient.
- div_r  in  WIDTH  divider remainder.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-operation):
  - state=IDLE, rr pointer ptr=0, watchdog counter=0.
  - gnt, done, div_start, tmo_out, dbz_out, ovf_out = 0.
  - q_out, r_out, div_x, div_y, res_id = 0.
  - Any in-flight divide is abandoned; a later div_valid is ignored until the next ISSUE.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any req bit is set, select the first set bit searching i = ptr, ptr+1, … mod NREQ.
  - Latch x_in/y_in of the winner into div_x/div_y and the winner index into res_id.
  - Go to ISSUE.
  - ptr is set to (winner+1) mod NREQ on the same edge.
- ISSUE (exactly 1 cycle):
  - div_start=1 and gnt[res_id]=1.
  - Clear the watchdog counter, then go to WAIT.
  - Latency from req sampled high in IDLE to gnt/start: 1 cycle.
- WAIT:
  - div_x/div_y are held stable for the whole divide.
  - Each cycle, if div_valid=1 and div_busy=0, capture div_q/div_r/div_dbz/div_ovf into q_out/r_out/dbz_out/ovf_out, set tmo_out=0, and go to DONE.
  - div_valid is never sampled in the ISSUE cycle, so a stale valid from a previous divide is not accepted.
  - Otherwise increment the counter.
  - When counter = TIMEOUT-1 without a result, go to DONE with q_out=0, r_out=0, dbz_out=0, ovf_out=0, tmo_out=1.
- DONE (exactly 1 cycle):
  - done[res_id]=1, then return to IDLE.
  - q_out/r_out/flags/res_id/tmo_out hold their values until the next capture or reset.
- Requester contract:
  - Hold req, x_in and y_in stable until gnt is seen.
  - Drop req in the cycle after gnt unless a further divide is wanted.
  - Dropping req before gnt withdraws the request; no divide is issued.
  - A requester re-raising req right after its own DONE takes lowest priority behind others (fairness).
- Throughput: one divide in flight. Back-to-back requests cost divider latency + 3 cycles (IDLE, ISSUE, DONE).
- Simultaneous events:
  - A req change in ISSUE/WAIT/DONE has no effect until the next IDLE.
  - If div_valid and the watchdog terminal count coincide, the valid result wins (tmo_out=0).
- gnt and done are never asserted together. div_start is high only in ISSUE.

Test Plan:
- Reset, then req=4'b0001 with x=32'h00800000 (0.5), y=32'h00080000 (0.03125), real divider attached:
  - gnt[0] and div_start pulse one cycle after req.
  - Then done[0]=1, res_id=0, q_out=32'h10000000 (16.0), dbz_out=ovf_out=tmo_out=0.
- req=4'b1111 held continuously with distinct operands:
  - Grants in order 0,1,2,3,0.
  - Each done matches its own quotient.
  - No gnt/done overlap; div_x/div_y stable throughout WAIT.
- req[2] with y=0:
  - done[2]=1, dbz_out=1, tmo_out=0.
  - Following req[1] with a valid divide clears dbz_out.
- Stub divider that never raises div_valid:
  - done pulses exactly TIMEOUT cycles after entering WAIT, with tmo_out=1, q_out=0.
  - Next request proceeds normally.
- Assert rst during WAIT of a divide for requester 3:
  - Next cycle all outputs are 0 and state=IDLE.
  - A late div_valid produces no done.
  - A new req[1] is granted with ptr restarting at 0.
- req[1] raised then dropped while a divide for requester 0 is in WAIT:
  - No grant for requester 1 after DONE.
  - State returns to IDLE with div_start=0.

Source files
------------

// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one fixed-point divider among NREQ requesters.
// Latches the winner's operands, pulses div_start and waits for the result
// under a watchdog. The result is then returned on a shared bus with a
// one-hot done strobe.
module fp_div_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FBITS   = 24,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     x_in,
  input  logic [NREQ*WIDTH-1:0]     y_in,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [WIDTH-1:0]          q_out,
  output logic [WIDTH-1:0]          r_out,
  output logic                      dbz_out,
  output logic                      ovf_out,
  output logic                      tmo_out,
  output logic                      div_start,
  output logic [WIDTH-1:0]          div_x,
  output logic [WIDTH-1:0]          div_y,
  input  logic                      div_busy,
  input  logic                      div_valid,
  input  logic                      div_dbz,
  input  logic                      div_ovf,
  input  logic [WIDTH-1:0]          div_q,
  input  logic [WIDTH-1:0]          div_r
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned CW  = $clog2(TIMEOUT);

  // Reject parameter sets the arbiter cannot support.
  if (FBITS >= WIDTH || NREQ < 2 || NREQ > 16 || TIMEOUT < 4) begin : g_param_check
    $error("fp_div_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [IDW-1:0]   ptr, ptr_d;
  logic [CW-1:0]    cnt, cnt_d;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW:0]     rr_idx;
  logic [WIDTH-1:0] x_sel, y_sel;

  logic [NREQ-1:0]  gnt_d, done_d;
  logic             start_d;
  logic [WIDTH-1:0] x_d, y_d, q_d, r_d;
  logic [IDW-1:0]   id_d;
  logic             dbz_d, ovf_d, tmo_d;

  // Round-robin search: first set req bit starting at ptr, wrapping mod NREQ.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      rr_idx = (IDW+1)'(ptr) + (IDW+1)'(k);
      if (rr_idx >= (IDW+1)'(NREQ)) begin
        rr_idx = rr_idx - (IDW+1)'(NREQ);
      end
      if (!found && req[rr_idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = rr_idx[IDW-1:0];
      end
    end
  end

  // Operand mux for the current round-robin winner.
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        x_sel = x_in[i*WIDTH +: WIDTH];
        y_sel = y_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output logic; registered outputs hold by default.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gnt_d   = '0;
    done_d  = '0;
    start_d = 1'b0;
    x_d     = div_x;
    y_d     = div_y;
    id_d    = res_id;
    q_d     = q_out;
    r_d     = r_out;
    dbz_d   = dbz_out;
    ovf_d   = ovf_out;
    tmo_d   = tmo_out;

    case (state)
      S_IDLE: begin
        if (found) begin
          x_d     = x_sel;
          y_d     = y_sel;
          id_d    = win;
          ptr_d   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          gnt_d   = NREQ'(1) << win;
          start_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A valid seen here belongs to an older divide and is ignored.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the terminal count still wins over the abort.
        if (div_valid && !div_busy) begin
          q_d     = div_q;
          r_d     = div_r;
          dbz_d   = div_dbz;
          ovf_d   = div_ovf;
          tmo_d   = 1'b0;
          done_d  = NREQ'(1) << res_id;
          state_d = S_DONE;
        end else if (cnt == CW'(TIMEOUT-1)) begin
          q_d     = '0;
          r_d     = '0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b1;
          done_d  = NREQ'(1) << res_id;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

  // Registered outputs: handshake strobes, divider operands and result bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      done      <= '0;
      div_start <= 1'b0;
      div_x     <= '0;
      div_y     <= '0;
      res_id    <= '0;
      q_out     <= '0;
      r_out     <= '0;
      dbz_out   <= 1'b0;
      ovf_out   <= 1'b0;
      tmo_out   <= 1'b0;
    end else begin
      gnt       <= gnt_d;
      done      <= done_d;
      div_start <= start_d;
      div_x     <= x_d;
      div_y     <= y_d;
      res_id    <= id_d;
      q_out     <= q_d;
      r_out     <= r_d;
      dbz_out   <= dbz_d;
      ovf_out   <= ovf_d;
      tmo_out   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with a behavioural divider model that can
// be stalled to exercise the watchdog.
`timescale 1ns/1ps
module tb_fp_div_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned FB = 24;
  localparam int unsigned N  = 4;
  localparam int unsigned TO = 64;

  localparam int          EXP_ORD [5] = '{0, 1, 2, 3, 0};
  localparam logic [31:0] P2_X    [4] = '{32'h01000000, 32'h03000000, 32'hFF000000, 32'h00C00000};
  localparam logic [31:0] P2_Y    [4] = '{32'h02000000, 32'h00800000, 32'h04000000, 32'h00400000};
  localparam logic [31:0] P2_Q    [4] = '{32'h00800000, 32'h06000000, 32'hFFC00000, 32'h03000000};

  logic               clk;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*W-1:0]     x_in, y_in;
  logic [N-1:0]       gnt, done;
  logic [1:0]         res_id;
  logic [W-1:0]       q_out, r_out;
  logic               dbz_out, ovf_out, tmo_out;
  logic               div_start;
  logic [W-1:0]       div_x, div_y;
  logic               div_busy, div_valid, div_dbz, div_ovf;
  logic [W-1:0]       div_q, div_r;

  int n_cmp, n_bad;
  int lat;
  bit stuck;
  bit mdl_clr;

  fp_div_arbiter #(.WIDTH(W), .FBITS(FB), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .y_in(y_in),
    .gnt(gnt), .done(done), .res_id(res_id), .q_out(q_out), .r_out(r_out),
    .dbz_out(dbz_out), .ovf_out(ovf_out), .tmo_out(tmo_out),
    .div_start(div_start), .div_x(div_x), .div_y(div_y),
    .div_busy(div_busy), .div_valid(div_valid), .div_dbz(div_dbz),
    .div_ovf(div_ovf), .div_q(div_q), .div_r(div_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signed Q8.24 divide: {dbz, ovf, q, r}.
  function automatic logic [65:0] fxdiv(input logic signed [31:0] a, input logic signed [31:0] b);
    longint num, q, r;
    logic   ov;
    if (b == 0) return {1'b1, 1'b0, 64'h0};
    num = longint'(a) <<< FB;
    q   = num / longint'(b);
    r   = num % longint'(b);
    ov  = (q > 64'sh000000007FFFFFFF) || (q < -64'sh0000000080000000);
    return {1'b0, ov, q[31:0], r[31:0]};
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    oh_idx = -1;
    for (int i = 0; i < int'(N); i++) if (v[i]) oh_idx = i;
  endfunction

  // Divider model: result lat cycles after start unless stuck.
  int                 m_cnt;
  bit                 m_act;
  logic signed [31:0] m_x, m_y;
  always @(posedge clk) begin
    if (mdl_clr) begin
      div_busy <= 1'b0; div_valid <= 1'b0; div_dbz <= 1'b0; div_ovf <= 1'b0;
      div_q <= '0; div_r <= '0; m_act <= 1'b0; m_cnt <= 0; m_x <= '0; m_y <= '0;
    end else begin
      div_valid <= 1'b0;
      if (div_start) begin
        m_act <= 1'b1; m_cnt <= lat; m_x <= div_x; m_y <= div_y; div_busy <= 1'b1;
      end else if (m_act) begin
        if (m_cnt > 1) m_cnt <= m_cnt - 1;
        else if (!stuck) begin
          m_act <= 1'b0; div_busy <= 1'b0; div_valid <= 1'b1;
          {div_dbz, div_ovf, div_q, div_r} <= fxdiv(m_x, m_y);
        end
      end
    end
  end

  // Protocol monitor: overlap, one-hot, start/gnt pairing, operand stability.
  int         ovl_err, oh_err, start_err, stab_err;
  bit         in_op;
  logic [31:0] rec_x, rec_y;
  int         gnt_log[$];
  int         done_id_log[$];
  logic [31:0] done_q_log[$];
  always @(negedge clk) begin
    if (mdl_clr) begin
      ovl_err <= 0; oh_err <= 0; start_err <= 0; stab_err <= 0;
      in_op <= 1'b0; rec_x <= '0; rec_y <= '0;
    end else if (rst) begin
      in_op <= 1'b0;
    end else begin
      if (gnt != '0 && done != '0) ovl_err <= ovl_err + 1;
      if (!$onehot0(gnt) || !$onehot0(done)) oh_err <= oh_err + 1;
      if (div_start != (gnt != '0)) start_err <= start_err + 1;
      if (gnt != '0) begin
        in_op <= 1'b1; rec_x <= div_x; rec_y <= div_y;
        gnt_log.push_back(oh_idx(gnt));
      end else if (in_op && (div_x != rec_x || div_y != rec_y)) begin
        stab_err <= stab_err + 1;
      end
      if (done != '0) begin
        in_op <= 1'b0;
        if (done != (4'b0001 << res_id)) oh_err <= oh_err + 1;
        done_id_log.push_back(int'(res_id));
        done_q_log.push_back(q_out);
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y);
    x_in[i*W +: W] = x;
    y_in[i*W +: W] = y;
  endtask

  task automatic wait_gnt(input string tag, input int maxc);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end while (gnt == '0 && c < maxc);
    if (gnt == '0) check({tag, "_gnt_timeout"}, 64'h0, 64'h1);
  endtask

  task automatic wait_done(input string tag, input int maxc, output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (done == '0 && cyc < maxc);
    if (done == '0) check({tag, "_done_timeout"}, 64'h0, 64'h1);
  endtask

  initial begin
    int cyc, nd, bad6;
    bit sawv;
    n_cmp = 0; n_bad = 0;
    mdl_clr = 1'b1; rst = 1'b1; req = '0; x_in = '0; y_in = '0; lat = 5; stuck = 1'b0;
    repeat (3) @(negedge clk);
    mdl_clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_start", 64'(div_start), 64'h0);
    check("rst_q", 64'(q_out), 64'h0);
    check("rst_resid", 64'(res_id), 64'h0);

    // 0.5 / 0.03125 = 16.0
    set_op(0, 32'h00800000, 32'h00080000);
    req = 4'b0001;
    @(negedge clk);
    check("p1_gnt", 64'(gnt), 64'h1);
    check("p1_start", 64'(div_start), 64'h1);
    req = '0;
    @(negedge clk);
    check("p1_gnt_pulse", 64'(gnt), 64'h0);
    wait_done("p1", 100, cyc);
    check("p1_done", 64'(done), 64'h1);
    check("p1_resid", 64'(res_id), 64'h0);
    check("p1_q", 64'(q_out), 64'h10000000);
    check("p1_r", 64'(r_out), 64'h0);
    check("p1_flags", 64'({dbz_out, ovf_out, tmo_out}), 64'h0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // All four requesting continuously.
    for (int i = 0; i < 4; i++) set_op(i, P2_X[i], P2_Y[i]);
    gnt_log.delete(); done_id_log.delete(); done_q_log.delete();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done("p2", 200, cyc);
    req = '0;
    @(negedge clk);
    check("p2_ngnt", 64'(gnt_log.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("p2_gnt%0d", k), 64'(gnt_log[k]), 64'(EXP_ORD[k]));
      check($sformatf("p2_did%0d", k), 64'(done_id_log[k]), 64'(EXP_ORD[k]));
      check($sformatf("p2_q%0d", k), 64'(done_q_log[k]), 64'(P2_Q[EXP_ORD[k]]));
    end

    // Divide by zero, then a clean divide clears the flag.
    set_op(2, 32'h01000000, 32'h00000000);
    req = 4'b0100;
    wait_gnt("p3a", 20);
    check("p3a_gnt", 64'(gnt), 64'h4);
    req = '0;
    wait_done("p3a", 100, cyc);
    check("p3a_done", 64'(done), 64'h4);
    check("p3a_dbz", 64'(dbz_out), 64'h1);
    check("p3a_tmo", 64'(tmo_out), 64'h0);
    set_op(1, 32'h02000000, 32'h01000000);
    req = 4'b0010;
    wait_gnt("p3b", 20);
    req = '0;
    wait_done("p3b", 100, cyc);
    check("p3b_done", 64'(done), 64'h2);
    check("p3b_dbz", 64'(dbz_out), 64'h0);
    check("p3b_q", 64'(q_out), 64'h02000000);

    // Watchdog: divider never answers.
    stuck = 1'b1;
    set_op(0, 32'h01000000, 32'h01000000);
    req = 4'b0001;
    wait_gnt("p4", 20);
    req = '0;
    wait_done("p4", int'(TO) + 20, cyc);
    check("p4_cycles", 64'(cyc), 64'(TO + 1));
    check("p4_done", 64'(done), 64'h1);
    check("p4_tmo", 64'(tmo_out), 64'h1);
    check("p4_q", 64'(q_out), 64'h0);
    check("p4_flags", 64'({dbz_out, ovf_out}), 64'h0);
    stuck = 1'b0;
    set_op(3, 32'h00C00000, 32'h00400000);
    req = 4'b1000;
    wait_gnt("p4b", 20);
    check("p4b_gnt", 64'(gnt), 64'h8);
    req = '0;
    wait_done("p4b", 100, cyc);
    check("p4b_q", 64'(q_out), 64'h03000000);
    check("p4b_tmo", 64'(tmo_out), 64'h0);
    check("p4b_resid", 64'(res_id), 64'h3);

    // Reset in the middle of a divide for requester 3.
    lat = 20;
    set_op(3, 32'h00C00000, 32'h00400000);
    req = 4'b1000;
    wait_gnt("p5", 20);
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("p5_rst_strobes", 64'({gnt, done, div_start}), 64'h0);
    check("p5_rst_flags", 64'({tmo_out, dbz_out, ovf_out}), 64'h0);
    check("p5_rst_q", 64'(q_out), 64'h0);
    check("p5_rst_r", 64'(r_out), 64'h0);
    check("p5_rst_divxy", {div_x, div_y}, 64'h0);
    check("p5_rst_resid", 64'(res_id), 64'h0);
    rst = 1'b0;
    nd = 0; sawv = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done != '0) nd++;
      if (div_valid) sawv = 1'b1;
    end
    check("p5_no_done", 64'(nd), 64'h0);
    check("p5_late_valid", 64'(sawv), 64'h1);
    lat = 5;
    set_op(1, 32'h02000000, 32'h01000000);
    req = 4'b0010;
    @(negedge clk);
    check("p5_gnt1", 64'(gnt), 64'h2);
    req = '0;
    wait_done("p5b", 100, cyc);
    check("p5b_q", 64'(q_out), 64'h02000000);
    check("p5b_resid", 64'(res_id), 64'h1);

    // Requester 1 raises then withdraws while requester 0 is in WAIT.
    lat = 8;
    set_op(0, 32'h03000000, 32'h00800000);
    req = 4'b0001;
    wait_gnt("p6", 20);
    req = '0;
    repeat (2) @(negedge clk);
    req = 4'b0010;
    repeat (2) @(negedge clk);
    req = '0;
    wait_done("p6", 100, cyc);
    check("p6_done", 64'(done), 64'h1);
    check("p6_q", 64'(q_out), 64'h06000000);
    bad6 = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt != '0 || div_start) bad6++;
    end
    check("p6_no_gnt", 64'(bad6), 64'h0);
    check("p6_start", 64'(div_start), 64'h0);

    check("mon_overlap", 64'(ovl_err), 64'h0);
    check("mon_onehot", 64'(oh_err), 64'h0);
    check("mon_start_gnt", 64'(start_err), 64'h0);
    check("mon_wait_stable", 64'(stab_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
